// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: filtered pin front end, byte FSM,
// auto-incrementing pointer, host parallel port and a write strobe per I2C byte.
module i2c_target_regfile #(
  parameter int unsigned NREGS     = 16,
  parameter int unsigned PTR_W     = 4,
  parameter int unsigned FILT_LEN  = 3,
  parameter logic [6:0]  ADDR_MASK = 7'h7F
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       own_addr_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_oen_o,
  input  logic [PTR_W-1:0] host_addr_i,
  input  logic [7:0]       host_wdata_i,
  input  logic             host_we_i,
  output logic [7:0]       host_rdata_o,
  output logic             wr_stb_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             busy_o
);

  localparam int unsigned FCNT_W = 4;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILT_LEN - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NREGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT
  } state_t;

  state_t state_q, state_d;

  // Index 1 = SCL, index 0 = SDA; idle bus level is high.
  logic [1:0]             sync1_q, sync2_q, filt_q, prev_q;
  logic [1:0][FCNT_W-1:0] fcnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '1;
      prev_q  <= '1;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= {scl_i, sda_i};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FCNT_MAX) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FCNT_W'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt_q[1];
  assign sda_f     = filt_q[0];
  assign scl_rise  = scl_f & ~prev_q[1];
  assign scl_fall  = ~scl_f & prev_q[1];
  assign start_det = scl_f & prev_q[0] & ~sda_f;
  assign stop_det  = scl_f & ~prev_q[0] & sda_f;

  logic [7:0]       regs [NREGS];
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d, rx_byte, rd_byte;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             mack_q, mack_d, busy_d, drv_d, commit;
  logic             addr_match;

  assign rx_byte    = {shift_q[6:0], sda_f};
  assign rd_byte    = regs[ptr_q];
  assign ptr_inc    = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
  assign addr_match = (((shift_q[7:1] ^ own_addr_i) & ADDR_MASK) == 7'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Byte sequencing; START/STOP override every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    busy_d  = busy_o;
    mack_d  = mack_q;
    drv_d   = ~sda_oen_o;
    commit  = 1'b0;
    if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = 4'd0;
      drv_d   = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      drv_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (state_q == S_WDATA && cnt_q == 4'd7) begin
              commit = 1'b1;
              ptr_d  = ptr_inc;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == S_ADDR) begin
              if (addr_match) begin
                state_d = S_ADDR_ACK;
                drv_d   = 1'b1;
                busy_d  = 1'b1;
              end else begin
                state_d = S_WAIT;
              end
            end else if (state_q == S_PTR) begin
              ptr_d   = shift_q[PTR_W-1:0];
              state_d = S_PTR_ACK;
              drv_d   = 1'b1;
            end else begin
              state_d = S_WDATA_ACK;
              drv_d   = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d = S_RDATA;
              shift_d = rd_byte;
              drv_d   = ~rd_byte[7];
              ptr_d   = ptr_inc;
            end else begin
              state_d = S_PTR;
              drv_d   = 1'b0;
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = S_WDATA;
            cnt_d   = 4'd0;
            drv_d   = 1'b0;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = S_RACK;
              cnt_d   = 4'd0;
              drv_d   = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              drv_d   = ~shift_q[6];
            end
          end
        end
        S_RACK: begin
          if (scl_rise) begin
            mack_d = ~sda_f;
          end else if (scl_fall) begin
            if (mack_q) begin
              state_d = S_RDATA;
              cnt_d   = 4'd0;
              shift_d = rd_byte;
              drv_d   = ~rd_byte[7];
              ptr_d   = ptr_inc;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      mack_q    <= 1'b0;
      busy_o    <= 1'b0;
      sda_o     <= 1'b1;
      sda_oen_o <= 1'b1;
      wr_stb_o  <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      mack_q    <= mack_d;
      busy_o    <= busy_d;
      sda_o     <= ~drv_d;
      sda_oen_o <= ~drv_d;
      wr_stb_o  <= commit;
      if (commit) begin
        wr_addr_o <= ptr_q;
        wr_data_o <= rx_byte;
      end
    end
  end

  // Register file: the I2C commit is assigned last so it wins a same-register collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      host_rdata_o <= '0;
    end else begin
      if (host_we_i) regs[host_addr_i] <= host_wdata_i;
      if (commit)    regs[ptr_q] <= rx_byte;
      if (commit && ptr_q == host_addr_i) host_rdata_o <= rx_byte;
      else if (host_we_i)                 host_rdata_o <= host_wdata_i;
      else                                host_rdata_o <= regs[host_addr_i];
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Scoreboarded bench for i2c_target_regfile: a bit-level I2C master drives the bus,
// expected ACKs/bytes/commits are queued and popped by monitors as responses appear.
module tb_i2c_target_regfile;

  localparam int LQ = 8;
  localparam int HP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_o, sda_oen_o;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_we = 1'b0;
  logic [7:0] host_rdata;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int tests = 0;
  int fails = 0;

  typedef struct { string nm; logic [7:0] v; } item_t;
  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
  item_t exp_bus_q[$];
  item_t obs_q[$];
  wr_t   exp_wr_q[$];

  logic watch = 1'b0;
  logic drove = 1'b0;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~(~sda_oen_o & ~sda_o);

  i2c_target_regfile #(
    .NREGS(16), .PTR_W(4), .FILT_LEN(3), .ADDR_MASK(7'h7C)
  ) dut (
    .clk_i(clk), .rst_i(rst), .own_addr_i(7'h50),
    .scl_i(scl), .sda_i(sda_line),
    .sda_o(sda_o), .sda_oen_o(sda_oen_o),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_we_i(host_we),
    .host_rdata_o(host_rdata),
    .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: response with no expectation queued", nm);
  endtask

  // Monitors: commit strobes and bus responses are checked against queued expectations.
  always @(negedge clk) begin : monitor
    wr_t   w;
    item_t o, e;
    if (wr_stb) begin
      if (exp_wr_q.size() == 0) fail_now("wr_stb");
      else begin
        w = exp_wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(w.a));
        check("wr_data", 32'(wr_data), 32'(w.d));
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_bus_q.size() == 0) fail_now(o.nm);
      else begin
        e = exp_bus_q.pop_front();
        check(e.nm, 32'(o.v), 32'(e.v));
      end
    end
  end

  always @(negedge clk) if (watch && !sda_oen_o) drove = 1'b1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b, input logic glitch, input logic coll);
    wait_cyc(LQ);
    sda_m = b;
    wait_cyc(LQ);
    scl = 1'b1;
    if (coll) begin
      // Host write lands on the same clock as the I2C commit (2 sync + 3 filter + 1 edge).
      wait_cyc(5);
      host_addr = 4'd5; host_wdata = 8'h77; host_we = 1'b1;
      wait_cyc(1);
      host_we = 1'b0;
      check("host_rdata_fwd", 32'(host_rdata), 32'h99);
      wait_cyc(HP - 6);
    end else if (glitch) begin
      wait_cyc(HP / 2);
      sda_m = ~b;
      wait_cyc(1);
      sda_m = b;
      wait_cyc(HP / 2 - 1);
    end else begin
      wait_cyc(HP);
    end
    scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_cyc(LQ);
    sda_m = 1'b1;
    wait_cyc(LQ);
    scl = 1'b1;
    wait_cyc(HP / 2);
    b = sda_line;
    wait_cyc(HP / 2);
    scl = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl = 1'b1;
    wait_cyc(HP);
    sda_m = 1'b0;
    wait_cyc(HP);
    scl = 1'b0;
  endtask

  task automatic bus_rstart();
    wait_cyc(LQ);
    sda_m = 1'b1;
    wait_cyc(LQ);
    scl = 1'b1;
    wait_cyc(HP);
    sda_m = 1'b0;
    wait_cyc(HP);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_cyc(LQ);
    sda_m = 1'b0;
    wait_cyc(LQ);
    scl = 1'b1;
    wait_cyc(HP);
    sda_m = 1'b1;
    wait_cyc(HP);
  endtask

  task automatic send_byte(input string nm, input logic [7:0] b, input logic exp_ack,
                           input int gl, input int co);
    item_t it;
    logic  a;
    it.nm = nm; it.v = {7'd0, exp_ack};
    exp_bus_q.push_back(it);
    for (int i = 0; i < 8; i++) write_bit(b[7-i], gl == i, co == i);
    read_bit(a);
    it.v = {7'd0, a};
    obs_q.push_back(it);
  endtask

  task automatic recv_byte(input string nm, input logic [7:0] exp_b, input logic ack);
    item_t      it;
    logic [7:0] d;
    logic       bt;
    it.nm = nm; it.v = exp_b;
    exp_bus_q.push_back(it);
    for (int i = 0; i < 8; i++) begin
      read_bit(bt);
      d = {d[6:0], bt};
    end
    it.v = d;
    obs_q.push_back(it);
    write_bit(!ack, 1'b0, 1'b0);
  endtask

  task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    exp_wr_q.push_back(w);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    wait_cyc(1);
    host_we = 1'b0;
  endtask

  task automatic host_read(input string nm, input logic [3:0] a, input logic [7:0] exp);
    host_addr = a;
    wait_cyc(1);
    check(nm, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    logic bt;
    wait_cyc(4);
    check("rst_sda_oen", 32'(sda_oen_o), 32'd1);
    check("rst_sda_o", 32'(sda_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    rst = 1'b0;
    wait_cyc(10);

    // Write pointer 3, two data bytes.
    exp_wr(4'd3, 8'h11);
    exp_wr(4'd4, 8'h22);
    bus_start();
    send_byte("wr_addr_ack", 8'hA0, 1'b0, -1, -1);
    check("busy_after_match", 32'(busy), 32'd1);
    send_byte("wr_ptr_ack", 8'h03, 1'b0, -1, -1);
    send_byte("wr_d0_ack", 8'h11, 1'b0, -1, -1);
    send_byte("wr_d1_ack", 8'h22, 1'b0, -1, -1);
    bus_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    host_read("host_reg4", 4'd4, 8'h22);
    host_read("host_reg3", 4'd3, 8'h11);

    // Read across the pointer wrap.
    host_write(4'd15, 8'hAB);
    host_write(4'd0, 8'hCD);
    bus_start();
    send_byte("rd_waddr_ack", 8'hA0, 1'b0, -1, -1);
    send_byte("rd_ptr_ack", 8'h0F, 1'b0, -1, -1);
    bus_rstart();
    send_byte("rd_raddr_ack", 8'hA1, 1'b0, -1, -1);
    recv_byte("rd_byte0", 8'hAB, 1'b1);
    recv_byte("rd_byte1", 8'hCD, 1'b0);
    wait_cyc(LQ);
    check("released_after_nack", 32'(sda_line), 32'd1);
    bus_stop();
    check("oen_after_read", 32'(sda_oen_o), 32'd1);

    // Masked address matching.
    bus_start();
    send_byte("mask_0x53_ack", 8'hA6, 1'b0, -1, -1);
    bus_stop();
    drove = 1'b0;
    watch = 1'b1;
    bus_start();
    send_byte("mask_0x54_nack", 8'hA8, 1'b1, -1, -1);
    check("mask_busy", 32'(busy), 32'd0);
    send_byte("mask_wait_nack", 8'h00, 1'b1, -1, -1);
    bus_stop();
    watch = 1'b0;
    check("mask_never_drove", 32'(drove), 32'd0);

    // Host/I2C collision on register 5.
    exp_wr(4'd5, 8'h99);
    bus_start();
    send_byte("col_addr_ack", 8'hA0, 1'b0, -1, -1);
    send_byte("col_ptr_ack", 8'h05, 1'b0, -1, -1);
    send_byte("col_data_ack", 8'h99, 1'b0, -1, 7);
    bus_stop();
    host_read("col_reg5", 4'd5, 8'h99);

    // Single-cycle SDA glitches during SCL high (fake STOP, then fake START).
    exp_wr(4'd7, 8'h5A);
    bus_start();
    send_byte("gl_addr_ack", 8'hA0, 1'b0, -1, -1);
    send_byte("gl_ptr_ack", 8'h07, 1'b0, 0, -1);
    send_byte("gl_data_ack", 8'h5A, 1'b0, 1, -1);
    bus_stop();
    host_read("gl_reg7", 4'd7, 8'h5A);

    // Reset while a read bit is pulling SDA low.
    bus_start();
    send_byte("rr_waddr_ack", 8'hA0, 1'b0, -1, -1);
    send_byte("rr_ptr_ack", 8'h08, 1'b0, -1, -1);
    bus_rstart();
    send_byte("rr_raddr_ack", 8'hA1, 1'b0, -1, -1);
    for (int i = 0; i < 3; i++) read_bit(bt);
    wait_cyc(LQ);
    check("rr_bit3_driven", 32'(sda_oen_o), 32'd0);
    rst = 1'b1;
    #1;
    check("rr_async_oen", 32'(sda_oen_o), 32'd1);
    check("rr_async_sda", 32'(sda_o), 32'd1);
    wait_cyc(3);
    rst = 1'b0;
    scl = 1'b1; sda_m = 1'b1;
    wait_cyc(HP);
    check("rr_busy", 32'(busy), 32'd0);
    host_read("rr_reg4_cleared", 4'd4, 8'h00);

    // Pointer restarts at 0 after reset, then a full write/read round trip.
    host_write(4'd0, 8'h5E);
    bus_start();
    send_byte("pr_raddr_ack", 8'hA1, 1'b0, -1, -1);
    recv_byte("pr_byte", 8'h5E, 1'b0);
    bus_stop();
    exp_wr(4'd9, 8'h3C);
    bus_start();
    send_byte("rt_waddr_ack", 8'hA0, 1'b0, -1, -1);
    send_byte("rt_ptr_ack", 8'h09, 1'b0, -1, -1);
    send_byte("rt_data_ack", 8'h3C, 1'b0, -1, -1);
    bus_stop();
    bus_start();
    send_byte("rt_waddr2_ack", 8'hA0, 1'b0, -1, -1);
    send_byte("rt_ptr2_ack", 8'h09, 1'b0, -1, -1);
    bus_rstart();
    send_byte("rt_raddr_ack", 8'hA1, 1'b0, -1, -1);
    recv_byte("rt_byte", 8'h3C, 1'b0);
    bus_stop();
    host_read("rt_reg9", 4'd9, 8'h3C);

    wait_cyc(20);
    check("bus_q_drained", 32'(exp_bus_q.size()), 32'd0);
    check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Synthesizable I2C target (slave) with an internal byte-wide register file, parametrised in register count, input filtering and address matching. It is the next-generation companion to the I2C master: it lets an SoC expose a configurable register bank on an external I2C bus, or stand in for EEPROM-style targets in benches. Host logic gets a direct parallel port into the same register file and a strobe for every byte the I2C master writes.

## Interface
- `NREGS`, 16: number of 8-bit registers, 2..256; the pointer wraps modulo `NREGS`.
- `PTR_W`, 4: pointer width, clog2(`NREGS`), ≤ 8.
- `FILT_LEN`, 3: number of consecutive equal samples required before a filtered SCL/SDA level changes, 1..15.
- `ADDR_MASK`, 7'h7F: per-bit address compare mask; 0 bits are don't-care, giving multi-address response.
- `clk_i` input 1: sole clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `own_addr_i` input 7: target address, quasi-static.
- `scl_i` input 1: SCL pin level; asynchronous.
- `sda_i` input 1: SDA pin level; asynchronous.
- `sda_o` input-side value driven to SDA: 0 = pull low, 1 = release. Direction output, width 1.
- `sda_oen_o` output 1: output enable, active-low; 0 only while pulling low.
- `host_addr_i` input `PTR_W`: host register index.
- `host_wdata_i` input 8: host write data.
- `host_we_i` input 1: host write enable, one register per cycle.
- `host_rdata_o` output 8: registered read of `host_addr_i`, 1-cycle latency.
- `wr_stb_o` output 1: one-cycle pulse when an I2C data byte is committed.
- `wr_addr_o` output `PTR_W`: register index of the committed byte, valid with `wr_stb_o`.
- `wr_data_o` output 8: committed byte, valid with `wr_stb_o`.
- `busy_o` output 1: high from a matched START+address until STOP.

## Operation
- Front end: 2-FF synchronizer on `scl_i`/`sda_i`, then a `FILT_LEN` stability filter. Edge detection uses the filtered levels.
- START/repeated START: filtered SDA falls while filtered SCL is high. Valid in any state and forces ADDR. STOP: SDA rises while SCL is high; forces IDLE and clears `busy_o`.
- Bits are sampled on the filtered SCL rising edge, MSB first. SDA drive changes only on the filtered SCL falling edge.
- States:
  - IDLE
  - ADDR: 8 bits
  - ADDR_ACK
  - PTR: 8 bits
  - PTR_ACK
  - WDATA: 8 bits
  - WDATA_ACK
  - RDATA: 8 bits driven
  - RACK: master ACK sampled
  - WAIT: ignore everything until START/STOP
- Address match: `(rx[7:1] ^ own_addr_i) & ADDR_MASK == 0`.
  - Mismatch: no ACK, go to WAIT.
  - Match with R/W=0: ACK, go to PTR.
  - Match with R/W=1: ACK, go to RDATA, loading the register at the current pointer.
- PTR byte: pointer ← `rx[PTR_W-1:0]`; upper bits ignored; ACK; go to WDATA.
- WDATA: on the 8th bit the register at pointer ← byte, pulse `wr_stb_o`, ACK, pointer ← (pointer+1) mod `NREGS`.
- RDATA: drive the register at pointer. After the byte, pointer increments (mod `NREGS`). In RACK, master ACK (SDA=0) → next RDATA; NACK → WAIT.
- The pointer persists across transactions, so a write-with-pointer followed by repeated-START read returns the addressed register. Reset pointer = 0.
- Collision: an I2C commit and `host_we_i` to the same register in the same cycle → the I2C byte wins. Different registers → both written.
- A read byte is latched into the shift register at RDATA entry; later host writes do not alter the byte in flight.

## Timing
- Reset values:
  - `sda_o`=1, `sda_oen_o`=1
  - `host_rdata_o`=0, `wr_stb_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `busy_o`=0
  - registers all 0, pointer 0, state IDLE
- Input latency: pin to filtered level is 2 + `FILT_LEN` cycles.
- Operating requirement: SCL high and low phases each ≥ `FILT_LEN`+6 `clk_i` cycles. No clock stretching.
- ACK: `sda_oen_o`/`sda_o` go low 1 cycle after the filtered SCL falling edge that ends bit 8, and release 1 cycle after the next filtered falling edge.
- Read bits update 1 cycle after the filtered SCL falling edge.
- `wr_stb_o` fires 1 cycle after the filtered SCL rising edge of bit 8.
- `host_rdata_o` reflects `host_addr_i` from the previous cycle, including a same-cycle I2C commit.
- `rst_i` mid-transfer: SDA is released immediately (asynchronous) and state returns to IDLE. The next bus activity is ignored until a START.

## Test plan
- Write: START, 0xA0 (own_addr=0x50), ptr 0x03, data 0x11, 0x22, STOP → ACK on all 4 bytes; `wr_stb_o` twice with (3,0x11),(4,0x22); host read of reg 4 = 0x22.
- Read with wrap (NREGS=16): preset reg15=0xAB, reg0=0xCD; write ptr 0x0F, repeated START, 0xA1, read 2 bytes with ACK then NACK → bytes 0xAB, 0xCD; the bus is then released.
- Mask: ADDR_MASK=7'h7C, own_addr=0x50; addresses 0x53 → ACK, 0x54 → NACK, SDA never driven, `busy_o` stays 0.
- Collision: `host_we_i` to reg 5 with 0x77 in the same cycle as an I2C commit of 0x99 to reg 5 → reg5=0x99.
- Glitch: 1-cycle SDA pulse while SCL is high (FILT_LEN=3) → no START/STOP detected, transfer continues intact.
- Reset mid-read while bit 3 is driving 0 → `sda_oen_o`=1 asynchronously; a subsequent full transaction completes normally.
